// File: rtl/jk_moore_bank.sv
// Bank of N independent J/K-driven on/off Moore machines with minimum dwell lock,
// registered rise/fall pulses and saturating per-channel transition counters.
// Ports: clk, reset (async, active-high), en (global enable), clr (sync clear, beats en),
//        j/k [N] set/clear requests -> out/rise/fall/busy [N], trans_cnt [N*CNT_W].
// Latency: j/k sampled at an edge, every output changes at that same edge; all outputs are flops.
module jk_moore_bank #(
  parameter int           N         = 4,
  parameter int           MIN_DWELL = 3,
  parameter int           CNT_W     = 8,
  parameter logic [N-1:0] INIT_VAL  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [N-1:0]       j,
  input  logic [N-1:0]       k,
  output logic [N-1:0]       out,
  output logic [N-1:0]       rise,
  output logic [N-1:0]       fall,
  output logic [N-1:0]       busy,
  output logic [N*CNT_W-1:0] trans_cnt
);

  // Dwell counter must hold MIN_DWELL; keep at least one bit so the vector is legal.
  localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);

  // Effective per-channel state: {level, dwell counter non-zero}.
  typedef enum logic [1:0] {
    S_OFF      = 2'b00,
    S_OFF_LOCK = 2'b01,
    S_ON       = 2'b10,
    S_ON_LOCK  = 2'b11
  } state_e;

  logic [N-1:0]            lvl_q, lvl_d;
  logic [N-1:0]            rise_q, rise_d;
  logic [N-1:0]            fall_q, fall_d;
  logic [N-1:0][DW-1:0]    dwell_q, dwell_d;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e       state [N];
  logic [N-1:0] take;

  // Decode state and decide which channels transition this edge (if enabled).
  // j=k=1 naturally toggles: OFF only looks at j, ON only looks at k.
  always_comb begin
    take = '0;
    for (int i = 0; i < N; i++) begin
      state[i] = state_e'({lvl_q[i], |dwell_q[i]});
      case (state[i])
        S_OFF:   take[i] = j[i];
        S_ON:    take[i] = k[i];
        default: take[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    lvl_d   = lvl_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        // Level jump to INIT_VAL is deliberately silent: no edge pulse.
        lvl_d[i]   = INIT_VAL[i];
        dwell_d[i] = '0;
        cnt_d[i]   = '0;
      end else if (en) begin
        if (take[i]) begin
          lvl_d[i]   = ~lvl_q[i];
          dwell_d[i] = DWELL_LOAD;
          rise_d[i]  = ~lvl_q[i];
          fall_d[i]  = lvl_q[i];
          if (cnt_q[i] != {CNT_W{1'b1}}) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else if (dwell_q[i] != '0) begin
          dwell_d[i] = dwell_q[i] - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q   <= INIT_VAL;
      dwell_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      lvl_q   <= lvl_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    out  = lvl_q;
    rise = rise_q;
    fall = fall_q;
    for (int i = 0; i < N; i++) begin
      busy[i] = |dwell_q[i];
    end
  end

  // Packed [N-1:0][CNT_W-1:0] places channel i at [i*CNT_W +: CNT_W].
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_jk_moore_bank.sv
// Scoreboard bench: two bank instances (dwell 3 / 2-bit counters, dwell 0 / 3-bit counters)
// share random and directed stimulus; a reference model pushes expected outputs per edge,
// a monitor pops and compares one cycle later; async reset checked immediately.
module tb_jk_moore_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] j;
  logic [3:0] k;

  logic [3:0]  out0, rise0, fall0, busy0;
  logic [7:0]  tc0;
  logic [3:0]  out1, rise1, fall1, busy1;
  logic [11:0] tc1;

  jk_moore_bank #(.N(4), .MIN_DWELL(3), .CNT_W(2), .INIT_VAL(4'b0101)) u0 (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .j(j), .k(k),
    .out(out0), .rise(rise0), .fall(fall0), .busy(busy0), .trans_cnt(tc0)
  );

  jk_moore_bank #(.N(4), .MIN_DWELL(0), .CNT_W(3), .INIT_VAL(4'b0011)) u1 (
    .clk(clk), .reset(rst), .en(en), .clr(clr), .j(j), .k(k),
    .out(out1), .rise(rise1), .fall(fall1), .busy(busy1), .trans_cnt(tc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  out;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  busy;
    logic [11:0] tc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: per channel the level, number of enabled edges since the last
  // transition (capped at the dwell), and an integer transition count clipped at max.
  int         md[2]   = '{3, 0};
  int         cmax[2] = '{3, 7};
  int         cw[2]   = '{2, 3};
  logic [3:0] init[2] = '{4'b0101, 4'b0011};

  bit m_lvl  [2][4];
  int m_since[2][4];
  int m_cnt  [2][4];
  bit m_rs   [2][4];
  bit m_fl   [2][4];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) begin
        m_lvl[u][c]   = init[u][c];
        m_since[u][c] = md[u];
        m_cnt[u][c]   = 0;
        m_rs[u][c]    = 1'b0;
        m_fl[u][c]    = 1'b0;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic c_in,
                            input logic [3:0] jj, input logic [3:0] kk);
    if (r || c_in) begin
      model_reset();
    end else begin
      for (int u = 0; u < 2; u++) begin
        for (int c = 0; c < 4; c++) begin
          bit want;
          m_rs[u][c] = 1'b0;
          m_fl[u][c] = 1'b0;
          if (e) begin
            want = m_lvl[u][c] ? kk[c] : jj[c];
            if (m_since[u][c] >= md[u] && want) begin
              m_lvl[u][c]   = !m_lvl[u][c];
              m_rs[u][c]    = m_lvl[u][c];
              m_fl[u][c]    = !m_lvl[u][c];
              m_since[u][c] = 0;
              m_cnt[u][c]   = (m_cnt[u][c] < cmax[u]) ? m_cnt[u][c] + 1 : cmax[u];
            end else if (m_since[u][c] < md[u]) begin
              m_since[u][c] = m_since[u][c] + 1;
            end
          end
        end
      end
    end
  endtask

  function automatic exp_t model_exp(int u);
    exp_t x;
    x = '0;
    for (int c = 0; c < 4; c++) begin
      x.out[c]  = m_lvl[u][c];
      x.rise[c] = m_rs[u][c];
      x.fall[c] = m_fl[u][c];
      x.busy[c] = (m_since[u][c] < md[u]);
      x.tc      = x.tc | (12'(m_cnt[u][c]) << (c * cw[u]));
    end
    return x;
  endfunction

  function automatic exp_t dut_act(int u);
    exp_t a;
    if (u == 0) a = '{out: out0, rise: rise0, fall: fall0, busy: busy0, tc: 12'(tc0)};
    else        a = '{out: out1, rise: rise1, fall: fall1, busy: busy1, tc: tc1};
    return a;
  endfunction

  task automatic cmp(input string name, input int u, input exp_t a, input exp_t e);
    checks += 5;
    if (a.out !== e.out) begin
      failures++;
      $display("FAIL %s u%0d out: got %b want %b @%0t", name, u, a.out, e.out, $time);
    end
    if (a.rise !== e.rise) begin
      failures++;
      $display("FAIL %s u%0d rise: got %b want %b @%0t", name, u, a.rise, e.rise, $time);
    end
    if (a.fall !== e.fall) begin
      failures++;
      $display("FAIL %s u%0d fall: got %b want %b @%0t", name, u, a.fall, e.fall, $time);
    end
    if (a.busy !== e.busy) begin
      failures++;
      $display("FAIL %s u%0d busy: got %b want %b @%0t", name, u, a.busy, e.busy, $time);
    end
    if (a.tc !== e.tc) begin
      failures++;
      $display("FAIL %s u%0d trans_cnt: got %h want %h @%0t", name, u, a.tc, e.tc, $time);
    end
  endtask

  // Inputs change on the falling edge; expected post-edge outputs are queued right away.
  task automatic drive(input logic r, input logic e, input logic c_in,
                       input logic [3:0] jj, input logic [3:0] kk);
    @(negedge clk);
    rst = r;
    en  = e;
    clr = c_in;
    j   = jj;
    k   = kk;
    model_step(r, e, c_in, jj, kk);
    q0.push_back(model_exp(0));
    q1.push_back(model_exp(1));
  endtask

  // Monitor: every rising edge produces a new output set; compare it 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) cmp("edge", 0, dut_act(0), q0.pop_front());
      if (q1.size() > 0) cmp("edge", 1, dut_act(1), q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    j   = '0;
    k   = '0;
    model_reset();
    #1;
    cmp("reset_init", 0, dut_act(0), model_exp(0));
    cmp("reset_init", 1, dut_act(1), model_exp(1));

    repeat (2) drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

    // Single set pulse then held clear on channel 1.
    drive(1'b0, 1'b1, 1'b0, 4'b0010, 4'h0);
    repeat (6) drive(1'b0, 1'b1, 1'b0, 4'h0, 4'b0010);

    // Continuous toggle request on channel 1.
    repeat (16) drive(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010);

    // Transition on channel 3, then freeze mid-lock.
    drive(1'b0, 1'b1, 1'b0, 4'b1000, 4'h0);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

    // Long toggle on channel 2 to hit counter saturation.
    repeat (25) drive(1'b0, 1'b1, 1'b0, 4'b0100, 4'b0100);

    // Clear beats enable and requests; no pulses from the clear itself.
    repeat (2) drive(1'b0, 1'b1, 1'b1, 4'hF, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 4'hF, 4'hF);

    for (int n = 0; n < 300; n++) begin
      drive(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
            4'($urandom & $urandom), 4'($urandom & $urandom));
    end

    // Async reset while channels 1 and 3 of u0 are in ON_LOCK.
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("async_rst", 0, dut_act(0), model_exp(0));
    cmp("async_rst", 1, dut_act(1), model_exp(1));
    drive(1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);

    for (int n = 0; n < 100; n++) begin
      drive(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0),
            4'($urandom), 4'($urandom));
    end

    @(posedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain: pending entries got %0d/%0d want 0/0", q0.size(), q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
